bulk_memory_responder: RTL and testbench

BULK_MEMORY_RESPONDER -- requirements
Module: bulk_memory_responder

---
 rtl/bulk_mem_pkg.sv | 20 ++
 rtl/bulk_mem_array.sv | 48 ++++
 rtl/bulk_memory_responder.sv | 133 +++++++++++++
 tb/tb_bulk_memory_responder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bulk_mem_pkg.sv
// Shared line geometry, line/strobe types and FSM state encoding for the bulk memory responder.
package bulk_mem_pkg;

    localparam int unsigned DEF_DATA_W    = 64;
    localparam int unsigned DEF_LINE_SIZE = 8;

    typedef logic [DEF_LINE_SIZE-1:0][DEF_DATA_W-1:0]   line_t;
    typedef logic [DEF_LINE_SIZE-1:0][DEF_DATA_W/8-1:0] strb_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    function automatic int unsigned line_bytes(int unsigned line_size, int unsigned data_w);
        return line_size * data_w / 8;
    endfunction

    function automatic int unsigned line_off(int unsigned line_size, int unsigned data_w);
        return $clog2(line_bytes(line_size, data_w));
    endfunction

endpackage

// File: rtl/bulk_mem_array.sv
// Line storage with a byte-strobed write port; the registered read port returns the
// post-write line, so a strobed write and a read share one access.
module bulk_mem_array
    import bulk_mem_pkg::*;
#(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned LINE_SIZE   = 8,
    parameter int unsigned DEPTH_LINES = 256
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic [$clog2(DEPTH_LINES)-1:0]        idx,
    input  logic [LINE_SIZE-1:0][DATA_W-1:0]      wdata,
    input  logic [LINE_SIZE-1:0][DATA_W/8-1:0]    wstrb,
    output logic [LINE_SIZE-1:0][DATA_W-1:0]      rdata
);

    logic [LINE_SIZE-1:0][DATA_W-1:0] mem [DEPTH_LINES];
    logic [LINE_SIZE-1:0][DATA_W-1:0] merged;

    always_comb begin
        merged = mem[idx];
        for (int w = 0; w < int'(LINE_SIZE); w++) begin
            for (int b = 0; b < int'(DATA_W / 8); b++) begin
                if (wstrb[w][b]) begin
                    merged[w][b*8 +: 8] = wdata[w][b*8 +: 8];
                end
            end
        end
    end

    // Contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[idx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= merged;
        end
    end

endmodule

// File: rtl/bulk_memory_responder.sv
// Responder end of a bulk line read/write interface: one line per request, one response
// pulse LATENCY cycles after accept, at most one request outstanding.
module bulk_memory_responder
    import bulk_mem_pkg::*;
#(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned LINE_SIZE   = 8,
    parameter int unsigned DEPTH_LINES = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    input  logic [ADDR_W-1:0]                  req_addr,
    input  logic                               req_write,
    input  logic [LINE_SIZE-1:0][DATA_W-1:0]   req_wdata,
    input  logic [LINE_SIZE-1:0][DATA_W/8-1:0] req_wstrb,
    input  logic                               dumping_cache,
    output logic                               req_ready,
    output logic                               resp_valid,
    output logic [LINE_SIZE-1:0][DATA_W-1:0]   resp_rdata
);

    localparam int unsigned OFF   = line_off(LINE_SIZE, DATA_W);
    localparam int unsigned IDX_W = $clog2(DEPTH_LINES);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    state_t                             state;
    logic [CNT_W-1:0]                   cnt;
    logic [ADDR_W-1:0]                  addr_q;
    logic                               write_q;
    logic [LINE_SIZE-1:0][DATA_W-1:0]   wdata_q;
    logic [LINE_SIZE-1:0][DATA_W/8-1:0] wstrb_q;

    logic                               accept;
    logic                               enter_resp;
    logic [IDX_W-1:0]                   arr_idx;
    logic [LINE_SIZE-1:0][DATA_W-1:0]   arr_wdata;
    logic [LINE_SIZE-1:0][DATA_W/8-1:0] arr_wstrb;
    logic [LINE_SIZE-1:0][DATA_W-1:0]   arr_rdata;
    logic                               unused_ok;

    assign accept     = req_valid && req_ready;
    assign enter_resp = (state == WAIT && cnt == CNT_W'(1)) || (accept && (LATENCY == 1));

    // With LATENCY == 1 the array is accessed on the accept edge itself, so it must see
    // the live request; otherwise the access happens from WAIT using the latched copy.
    always_comb begin
        if (state == WAIT) begin
            arr_idx   = addr_q[OFF +: IDX_W];
            arr_wdata = wdata_q;
            arr_wstrb = write_q ? wstrb_q : '0;
        end else begin
            arr_idx   = req_addr[OFF +: IDX_W];
            arr_wdata = req_wdata;
            arr_wstrb = req_write ? req_wstrb : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            unique case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        addr_q  <= req_addr;
                        write_q <= req_write;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            req_ready  <= 1'b1;
                        end else begin
                            state      <= WAIT;
                            cnt        <= CNT_W'(LATENCY - 1);
                            resp_valid <= 1'b0;
                            req_ready  <= 1'b0;
                        end
                    end else begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        state      <= RESP;
                        cnt        <= '0;
                        resp_valid <= 1'b1;
                        req_ready  <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

    bulk_mem_array #(
        .DATA_W      (DATA_W),
        .LINE_SIZE   (LINE_SIZE),
        .DEPTH_LINES (DEPTH_LINES)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (enter_resp),
        .idx   (arr_idx),
        .wdata (arr_wdata),
        .wstrb (arr_wstrb),
        .rdata (arr_rdata)
    );

    assign resp_rdata = resp_valid ? arr_rdata : '0;

    // Offset/upper address bits and dumping_cache carry no meaning for this responder.
    assign unused_ok = ^{dumping_cache, req_addr, addr_q};

endmodule

// File: tb/tb_bulk_memory_responder.sv
// Randomised self-checking bench: a LATENCY=2 and a LATENCY=1 responder share stimulus and
// are compared against a line-array model of the memory.
module tb_bulk_memory_responder;
    import bulk_mem_pkg::*;

    localparam int L2 = 2;
    localparam logic [3:0] EXP_V = 4'b0010;  // resp_valid at negedges 1..4 after accept
    localparam logic [3:0] EXP_R = 4'b1110;  // req_ready low only in the WAIT cycle

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_write;
    line_t       req_wdata;
    strb_t       req_wstrb;
    logic        dumping_cache;
    logic        rdy2, rv2, rdy1, rv1;
    line_t       rd2, rd1;

    int checks = 0;
    int passes = 0;
    line_t model_mem [256];

    always #5 clk = ~clk;

    bulk_memory_responder #(.LATENCY(L2)) d2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .dumping_cache(dumping_cache), .req_ready(rdy2), .resp_valid(rv2), .resp_rdata(rd2)
    );

    bulk_memory_responder #(.LATENCY(1)) d1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .dumping_cache(dumping_cache), .req_ready(rdy1), .resp_valid(rv1), .resp_rdata(rd1)
    );

    function automatic line_t rand_line();
        line_t l;
        for (int w = 0; w < 8; w++) l[w] = {$urandom, $urandom};
        return l;
    endfunction

    function automatic strb_t rand_strb();
        strb_t s;
        for (int w = 0; w < 8; w++) s[w] = 8'($urandom);
        return s;
    endfunction

    function automatic line_t merge(line_t old, line_t wd, strb_t ws);
        line_t n = old;
        for (int w = 0; w < 8; w++)
            for (int b = 0; b < 8; b++)
                if (ws[w][b]) n[w][b*8 +: 8] = wd[w][b*8 +: 8];
        return n;
    endfunction

    // 64-byte lines, 256 of them: index is the line number modulo 256.
    function automatic int idx_of(logic [63:0] a);
        return int'((a / 64) % 256);
    endfunction

    function automatic logic [63:0] addr_for(int idx);
        return ({$urandom, $urandom} << 14) | (64'(idx) << 6) | 64'($urandom_range(63, 0));
    endfunction

    function automatic line_t model_access(logic [63:0] a, logic w, line_t wd, strb_t ws);
        int i = idx_of(a);
        if (w) model_mem[i] = merge(model_mem[i], wd, ws);
        return model_mem[i];
    endfunction

    task automatic txn2(input logic [63:0] a, input logic w, input line_t wd, input strb_t ws,
                        output logic [3:0] vpat, output logic [3:0] rpat, output line_t got,
                        output logic leak, output logic tmo);
        int n = 0;
        vpat = '0; rpat = '0; got = '0; leak = 1'b0; tmo = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = wd; req_wstrb = ws;
        dumping_cache = 1'($urandom);
        while (rdy2 !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (rdy2 !== 1'b1) begin
            tmo = 1'b1;
            req_valid = 1'b0;
            return;
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            vpat[k-1] = rv2;
            rpat[k-1] = rdy2;
            if (k == L2) got = rd2;
            else if (rd2 !== '0) leak = 1'b1;
            if (k == 1) begin
                req_valid = 1'b0; req_addr = {$urandom, $urandom}; req_write = 1'($urandom);
                req_wdata = rand_line(); req_wstrb = rand_strb();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b1; req_addr = 64'h40;
        repeat (3) @(negedge clk);
        checks++; if (rdy2 !== 1'b0) $display("FAIL reset_ready got=%b exp=0", rdy2); else passes++;
        checks++; if (rv2 !== 1'b0) $display("FAIL reset_valid got=%b exp=0", rv2); else passes++;
        checks++; if (rd2 !== '0) $display("FAIL reset_rdata got=%h exp=0", rd2); else passes++;
        checks++; if (rdy1 !== 1'b0 || rv1 !== 1'b0) $display("FAIL reset_lat1 rdy=%b v=%b exp=0,0", rdy1, rv1); else passes++;
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (rdy2 !== 1'b1 || rdy1 !== 1'b1) $display("FAIL ready_after_reset got=%b%b exp=11", rdy2, rdy1); else passes++;
        checks++; if (rv2 !== 1'b0) $display("FAIL valid_after_reset got=%b exp=0", rv2); else passes++;
    endtask

    task automatic test_init();
        logic [3:0] vpat, rpat; line_t wd, got, e; logic leak, tmo; logic [63:0] a;
        for (int i = 0; i < 8; i++) begin
            a = addr_for(i); wd = rand_line();
            e = model_access(a, 1'b1, wd, '1);
            txn2(a, 1'b1, wd, '1, vpat, rpat, got, leak, tmo);
            checks++;
            if (tmo || vpat !== EXP_V || got !== e)
                $display("FAIL init[%0d] tmo=%b vpat=%b got=%h exp=%h", i, tmo, vpat, got, e);
            else passes++;
        end
    endtask

    task automatic test_read_timing();
        logic [3:0] vpat, rpat; line_t got, e; logic leak, tmo;
        e = model_access(64'h40, 1'b0, '0, '0);
        txn2(64'h40, 1'b0, '0, '0, vpat, rpat, got, leak, tmo);
        checks++; if (tmo || vpat !== EXP_V) $display("FAIL read_valid_timing got=%b exp=%b tmo=%b", vpat, EXP_V, tmo); else passes++;
        checks++; if (rpat !== EXP_R) $display("FAIL read_ready_pattern got=%b exp=%b", rpat, EXP_R); else passes++;
        checks++; if (got !== e) $display("FAIL read_data got=%h exp=%h", got, e); else passes++;
        checks++; if (leak) $display("FAIL rdata_outside_resp got=nonzero exp=0"); else passes++;
    endtask

    task automatic test_partial_write();
        logic [3:0] vpat, rpat; line_t wd, got, e; strb_t ws; logic leak, tmo;
        wd = '0; wd[0] = 64'h1122334455667788;
        ws = '0; ws[0] = 8'h0F;
        e = model_mem[1];
        e[0][31:0] = 32'h55667788;
        void'(model_access(64'h40, 1'b1, wd, ws));
        txn2(64'h40, 1'b1, wd, ws, vpat, rpat, got, leak, tmo);
        checks++; if (tmo || vpat !== EXP_V || got !== e) $display("FAIL partial_write_resp got=%h exp=%h", got, e); else passes++;
        txn2(64'h40, 1'b0, '0, '0, vpat, rpat, got, leak, tmo);
        checks++; if (tmo || got !== e) $display("FAIL partial_write_read got=%h exp=%h", got, e); else passes++;
    endtask

    task automatic test_zero_strobe();
        logic [3:0] vpat, rpat; line_t got, e; logic leak, tmo; logic [63:0] a;
        a = addr_for(3);
        e = model_mem[3];
        txn2(a, 1'b1, rand_line(), '0, vpat, rpat, got, leak, tmo);
        checks++; if (tmo || vpat !== EXP_V || got !== e) $display("FAIL zero_strobe_resp vpat=%b got=%h exp=%h", vpat, got, e); else passes++;
        txn2(addr_for(3), 1'b0, '0, '0, vpat, rpat, got, leak, tmo);
        checks++; if (tmo || got !== e) $display("FAIL zero_strobe_unchanged got=%h exp=%h", got, e); else passes++;
    endtask

    task automatic test_wrap();
        logic [3:0] vpat, rpat; line_t x, got; logic leak, tmo;
        x = rand_line();
        void'(model_access(64'h4040, 1'b1, x, '1));
        txn2(64'h4040, 1'b1, x, '1, vpat, rpat, got, leak, tmo);
        checks++; if (tmo || got !== x) $display("FAIL wrap_write got=%h exp=%h", got, x); else passes++;
        txn2(64'h47, 1'b0, '0, '0, vpat, rpat, got, leak, tmo);
        checks++; if (tmo || got !== model_mem[1]) $display("FAIL wrap_read_47 got=%h exp=%h", got, model_mem[1]); else passes++;
        txn2(64'h40, 1'b0, '0, '0, vpat, rpat, got, leak, tmo);
        checks++; if (tmo || got !== x) $display("FAIL wrap_read_40 got=%h exp=%h", got, x); else passes++;
    endtask

    task automatic test_back_to_back();
        line_t expq[$]; int resp_cyc[$]; line_t e;
        int issued = 0, got_n = 0;
        logic acc, prev_acc = 1'b0;
        @(negedge clk);
        req_addr = addr_for($urandom_range(7, 0)); req_write = 1'b0; req_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && got_n < 6; cyc++) begin
            if (rv2 === 1'b1) begin
                if (expq.size() > 0) e = expq.pop_front(); else e = '0;
                checks++;
                if (rd2 !== e) $display("FAIL b2b_data[%0d] got=%h exp=%h", got_n, rd2, e);
                else passes++;
                resp_cyc.push_back(cyc);
                got_n++;
            end
            if (prev_acc) begin
                checks++; if (rdy2 !== 1'b0) $display("FAIL b2b_ready_in_wait got=%b exp=0", rdy2); else passes++;
            end
            acc = req_valid && (rdy2 === 1'b1);
            if (acc) begin
                expq.push_back(model_access(req_addr, 1'b0, '0, '0));
                issued++;
            end
            prev_acc = acc;
            @(posedge clk);
            #1;
            if (acc) begin
                if (issued < 6) req_addr = addr_for($urandom_range(7, 0));
                else req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++; if (got_n != 6) $display("FAIL b2b_count got=%0d exp=6", got_n); else passes++;
        for (int i = 1; i < resp_cyc.size(); i++) begin
            checks++;
            if (resp_cyc[i] - resp_cyc[i-1] != L2)
                $display("FAIL b2b_spacing[%0d] got=%0d exp=%0d", i, resp_cyc[i] - resp_cyc[i-1], L2);
            else passes++;
        end
    endtask

    task automatic test_random();
        logic [3:0] vpat, rpat; line_t wd, got, e; strb_t ws; logic leak, tmo, w; logic [63:0] a;
        for (int i = 0; i < 16; i++) begin
            a = addr_for($urandom_range(7, 0)); w = 1'($urandom); wd = rand_line();
            ws = ($urandom_range(3, 0) == 0) ? strb_t'('0) : rand_strb();
            e = model_access(a, w, wd, ws);
            txn2(a, w, wd, ws, vpat, rpat, got, leak, tmo);
            checks++;
            if (tmo || vpat !== EXP_V || got !== e || leak)
                $display("FAIL random[%0d] w=%b vpat=%b leak=%b got=%h exp=%h", i, w, vpat, leak, got, e);
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] vpat, rpat; line_t got, e; logic leak, tmo, bad; logic [63:0] a;
        a = addr_for(5);
        @(negedge clk);
        req_addr = a; req_write = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (rdy2 !== 1'b0) $display("FAIL mid_in_wait ready got=%b exp=0", rdy2); else passes++;
        rst = 1'b0;
        #1;
        checks++;
        if (rdy2 !== 1'b0 || rv2 !== 1'b0 || rd2 !== '0)
            $display("FAIL mid_reset_outputs rdy=%b v=%b exp=0,0", rdy2, rv2);
        else passes++;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rv2 !== 1'b0 || rdy2 !== 1'b0) bad = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (rdy2 !== 1'b1) $display("FAIL mid_ready_after got=%b exp=1", rdy2); else passes++;
        if (rv2 !== 1'b0) bad = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rv2 !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) $display("FAIL mid_dropped_request got=pulse exp=none"); else passes++;
        e = model_access(a, 1'b0, '0, '0);
        txn2(a, 1'b0, '0, '0, vpat, rpat, got, leak, tmo);
        checks++; if (tmo || got !== e) $display("FAIL storage_kept got=%h exp=%h", got, e); else passes++;
    endtask

    task automatic test_lat1();
        logic [63:0] a; line_t x, p, m; strb_t s;
        a = addr_for(2); x = rand_line(); p = rand_line(); s = rand_strb();
        m = merge(x, p, s);
        @(negedge clk);
        checks++; if (rdy1 !== 1'b1) $display("FAIL lat1_ready got=%b exp=1", rdy1); else passes++;
        req_valid = 1'b1; req_addr = a; req_write = 1'b1; req_wdata = x; req_wstrb = '1;
        @(negedge clk);
        checks++; if (rv1 !== 1'b1 || rd1 !== x) $display("FAIL lat1_write v=%b got=%h exp=%h", rv1, rd1, x); else passes++;
        req_addr = addr_for(2); req_wdata = p; req_wstrb = s;
        @(negedge clk);
        checks++; if (rv1 !== 1'b1 || rd1 !== m) $display("FAIL lat1_merge v=%b got=%h exp=%h", rv1, rd1, m); else passes++;
        req_addr = addr_for(2); req_write = 1'b0; req_wstrb = rand_strb();
        @(negedge clk);
        checks++; if (rv1 !== 1'b1 || rd1 !== m) $display("FAIL lat1_raw v=%b got=%h exp=%h", rv1, rd1, m); else passes++;
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (rv1 !== 1'b0 || rd1 !== '0) $display("FAIL lat1_idle v=%b got=%h exp=0", rv1, rd1); else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
        req_wdata = '0; req_wstrb = '0; dumping_cache = 1'b0;
        test_reset();
        test_init();
        test_read_timing();
        test_partial_write();
        test_zero_strobe();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_lat1();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
